// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int BS_MAX_W = 256;

  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reverse the lowest nbytes bytes of d; bytes above nbytes come out zero.
  function automatic logic [BS_MAX_W-1:0] byte_swap(input logic [BS_MAX_W-1:0] d,
                                                    input int nbytes);
    logic [BS_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BS_MAX_W / 8; i++) begin
      if (i < nbytes) begin
        r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
      end else begin
        r[8*i +: 8] = 8'h00;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_n_rr_picker.sv
// One-hot picker: first set request at or after ptr_i (wrapping), or from
// index 0 when rr_en_i is low.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          rr_en_i,
  output logic [N-1:0]  sel_o
);

  logic [IW-1:0]  start_s;
  logic [2*N-1:0] dbl_s;
  logic [2*N-1:0] back_s;
  logic [N-1:0]   rot_s;
  logic [N-1:0]   pick_s;
  logic           found_s;

  // Rotate so the start index sits at bit 0, pick lowest, rotate back.
  assign start_s = rr_en_i ? ptr_i : '0;
  assign dbl_s   = {req_i, req_i} >> start_s;
  assign rot_s   = dbl_s[N-1:0];

  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      pick_s[k] = rot_s[k] & ~found_s;
      found_s   = found_s | rot_s[k];
    end
  end

  assign back_s = {pick_s, pick_s} << start_s;
  assign sel_o  = back_s[2*N-1:N];

endmodule

// File: rtl/mem_arbiter_n.sv
// N-port arbiter in front of a single-port synchronous memory with 1-cycle
// read latency; fixed or round-robin selection with burst locking.
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int MEM_AW     = 12,
  parameter int RR_MODE    = 1,
  parameter int SWAP_BYTES = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_PORTS-1:0]        req_valid_i,
  input  logic [NUM_PORTS-1:0]        req_we_i,
  input  logic [NUM_PORTS-1:0]        req_lock_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata_i,
  output logic [NUM_PORTS-1:0]        gnt_o,
  output logic [MEM_AW-1:0]           mem_addr_o,
  output logic                        mem_re_o,
  output logic                        mem_we_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  output logic [NUM_PORTS-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_rdata_o
);

  localparam int IW    = port_idx_w(NUM_PORTS);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        rsp_idx_q, rsp_idx_d;
  logic                 rsp_vld_q, rsp_vld_d;

  logic                 rr_en_s;
  logic [NUM_PORTS-1:0] pick_s;
  logic [NUM_PORTS-1:0] gnt_s;
  logic [IW-1:0]        win_s;
  logic                 xfer_s;
  logic                 win_we_s;
  logic                 win_lock_s;
  logic [ADDR_W-1:0]    win_addr_s;
  logic [ADDR_W-1:0]    word_addr_s;
  logic [DATA_W-1:0]    win_wdata_s;
  logic                 unused_addr_s;

  function automatic logic [DATA_W-1:0] swap_data(input logic [DATA_W-1:0] d);
    logic [BS_MAX_W-1:0] t;
    t = byte_swap(BS_MAX_W'(d), NB);
    return (SWAP_BYTES != 0) ? t[DATA_W-1:0] : d;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (p == IW'(NUM_PORTS - 1)) ? '0 : p + IW'(1);
  endfunction

  assign rr_en_s = (RR_MODE != 0);

  rr_picker #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_picker (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .rr_en_i (rr_en_s),
    .sel_o   (pick_s)
  );

  // While locked only the owner can win; reset masks every grant.
  always_comb begin
    gnt_s = '0;
    if (!rst_ni) begin
      gnt_s = '0;
    end else if (state_q == LOCKED) begin
      gnt_s[owner_q] = req_valid_i[owner_q];
    end else begin
      gnt_s = pick_s;
    end
  end

  always_comb begin
    win_s       = '0;
    win_we_s    = 1'b0;
    win_lock_s  = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      win_s       = win_s | (gnt_s[p] ? IW'(p) : '0);
      win_we_s    = win_we_s | (gnt_s[p] & req_we_i[p]);
      win_lock_s  = win_lock_s | (gnt_s[p] & req_lock_i[p]);
      win_addr_s  = win_addr_s | (req_addr_i[p*ADDR_W +: ADDR_W] & {ADDR_W{gnt_s[p]}});
      win_wdata_s = win_wdata_s | (req_wdata_i[p*DATA_W +: DATA_W] & {DATA_W{gnt_s[p]}});
    end
  end

  assign xfer_s        = |gnt_s;
  assign word_addr_s   = win_addr_s >> OFF_W;
  assign unused_addr_s = ^win_addr_s;

  assign gnt_o       = gnt_s;
  assign mem_addr_o  = word_addr_s[MEM_AW-1:0];
  assign mem_re_o    = xfer_s & ~win_we_s;
  assign mem_we_o    = xfer_s & win_we_s;
  assign mem_wdata_o = (xfer_s & win_we_s) ? swap_data(win_wdata_s) : '0;

  always_comb begin
    rsp_valid_o            = '0;
    rsp_valid_o[rsp_idx_q] = rsp_vld_q;
  end

  assign rsp_rdata_o = rsp_vld_q ? swap_data(mem_rdata_i) : '0;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    rsp_vld_d = xfer_s & ~win_we_s;
    rsp_idx_d = win_s;
    case (state_q)
      ARB: begin
        if (xfer_s && win_lock_s) begin
          state_d = LOCKED;
          owner_d = win_s;
        end else if (xfer_s) begin
          ptr_d = next_ptr(win_s);
        end else begin
          ptr_d = ptr_q;
        end
      end
      LOCKED: begin
        // The unlocked closing beat releases the bus and moves past the owner.
        if (xfer_s && !win_lock_s) begin
          state_d = ARB;
          ptr_d   = next_ptr(owner_q);
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ARB;
      owner_q   <= '0;
      ptr_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_idx_q <= rsp_idx_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share the
// same stimulus and are compared against a behavioural model.
module tb_mem_arbiter_n;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 16;
  localparam int MAW = 12;

  logic            clk_i  = 1'b0;
  logic            rst_ni = 1'b0;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_we_i;
  logic [N-1:0]    req_lock_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [DW-1:0]   mem_rdata_i;

  logic [N-1:0]    gnt_s       [2];
  logic [N-1:0]    rsp_valid_s [2];
  logic [MAW-1:0]  mem_addr_s  [2];
  logic            mem_re_s    [2];
  logic            mem_we_s    [2];
  logic [DW-1:0]   mem_wdata_s [2];
  logic [DW-1:0]   rsp_rdata_s [2];

  int n_vec = 0;
  int n_err = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  int ptr    [2];
  int owner  [2];
  int pend_p [2];
  bit locked [2];
  bit pend_v [2];
  int rr     [2] = '{1, 0};

  always #5 clk_i = ~clk_i;

  mem_arbiter_n #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MEM_AW(MAW),
                  .RR_MODE(1), .SWAP_BYTES(1)) u_dut_rr (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
    .req_lock_i(req_lock_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .gnt_o(gnt_s[0]), .mem_addr_o(mem_addr_s[0]), .mem_re_o(mem_re_s[0]),
    .mem_we_o(mem_we_s[0]), .mem_wdata_o(mem_wdata_s[0]), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_s[0]), .rsp_rdata_o(rsp_rdata_s[0]));

  mem_arbiter_n #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MEM_AW(MAW),
                  .RR_MODE(0), .SWAP_BYTES(1)) u_dut_fix (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
    .req_lock_i(req_lock_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .gnt_o(gnt_s[1]), .mem_addr_o(mem_addr_s[1]), .mem_re_o(mem_re_s[1]),
    .mem_we_o(mem_we_s[1]), .mem_wdata_o(mem_wdata_s[1]), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_s[1]), .rsp_rdata_o(rsp_rdata_s[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] swap16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  function automatic string nm(input int m, input string s);
    return {(m == 0) ? "rr " : "fix ", s};
  endfunction

  task automatic clear_all();
    req_valid_i = '0;
    req_we_i    = '0;
    req_lock_i  = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
  endtask

  task automatic set_req(input int p, input bit v, input bit we, input bit lk,
                         input logic [31:0] a, input logic [15:0] d);
    req_valid_i[p]          = v;
    req_we_i[p]             = we;
    req_lock_i[p]           = lk;
    req_addr_i[p*AW +: AW]  = a;
    req_wdata_i[p*DW +: DW] = d;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ptr[m]    = 0;
      locked[m] = 1'b0;
      pend_v[m] = 1'b0;
    end
  endtask

  // Expected winner from the arbitration rules, -1 when nobody is granted.
  function automatic int exp_winner(input int m);
    int p;
    if (locked[m]) return req_valid_i[owner[m]] ? owner[m] : -1;
    for (int k = 0; k < N; k++) begin
      p = ((rr[m] != 0 ? ptr[m] : 0) + k) % N;
      if (req_valid_i[p]) return p;
    end
    return -1;
  endfunction

  task automatic check_outputs(input int m, input int w);
    logic [31:0] a;
    logic [31:0] g;
    bit          rd;
    bit          wr;
    logic [15:0] wd;
    a  = 32'd0;
    g  = 32'd0;
    wd = 16'd0;
    rd = 1'b0;
    wr = 1'b0;
    if (w >= 0) begin
      a  = req_addr_i[w*AW +: AW];
      g  = 32'd1 << w;
      rd = !req_we_i[w];
      wr = req_we_i[w];
      wd = wr ? swap16(req_wdata_i[w*DW +: DW]) : 16'd0;
    end
    check(nm(m, "gnt"), 32'(gnt_s[m]), g);
    check(nm(m, "mem_addr"), 32'(mem_addr_s[m]), (a >> 1) & 32'h0000_0FFF);
    check(nm(m, "mem_re"), 32'(mem_re_s[m]), 32'(rd));
    check(nm(m, "mem_we"), 32'(mem_we_s[m]), 32'(wr));
    check(nm(m, "mem_wdata"), 32'(mem_wdata_s[m]), 32'(wd));
    check(nm(m, "rsp_valid"), 32'(rsp_valid_s[m]), pend_v[m] ? (32'd1 << pend_p[m]) : 32'd0);
    if (pend_v[m]) check(nm(m, "rsp_rdata"), 32'(rsp_rdata_s[m]), 32'(swap16(mem_rdata_i)));
  endtask

  task automatic commit(input int m, input int w);
    pend_v[m] = (w >= 0) && !req_we_i[w];
    pend_p[m] = w;
    if (w >= 0) begin
      if (locked[m]) begin
        if (!req_lock_i[w]) begin
          locked[m] = 1'b0;
          ptr[m]    = (w + 1) % N;
        end
      end else if (req_lock_i[w]) begin
        locked[m] = 1'b1;
        owner[m]  = w;
      end else begin
        ptr[m] = (w + 1) % N;
      end
    end
  endtask

  // Called at posedge+1 with inputs already applied; returns at next posedge+1.
  task automatic step();
    int w [2];
    #3;
    for (int m = 0; m < 2; m++) begin
      w[m] = exp_winner(m);
      check_outputs(m, w[m]);
    end
    @(posedge clk_i);
    for (int m = 0; m < 2; m++) commit(m, w[m]);
    #1;
    mem_rdata_i = 16'($urandom);
  endtask

  task automatic check_reset();
    for (int m = 0; m < 2; m++) begin
      check(nm(m, "rst gnt"), 32'(gnt_s[m]), 32'd0);
      check(nm(m, "rst mem_addr"), 32'(mem_addr_s[m]), 32'd0);
      check(nm(m, "rst mem_re"), 32'(mem_re_s[m]), 32'd0);
      check(nm(m, "rst mem_we"), 32'(mem_we_s[m]), 32'd0);
      check(nm(m, "rst mem_wdata"), 32'(mem_wdata_s[m]), 32'd0);
      check(nm(m, "rst rsp_valid"), 32'(rsp_valid_s[m]), 32'd0);
      check(nm(m, "rst rsp_rdata"), 32'(rsp_rdata_s[m]), 32'd0);
    end
  endtask

  initial begin
    clear_all();
    mem_rdata_i = 16'hBEEF;
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h40, 16'h0);
    set_req(2, 1'b1, 1'b1, 1'b0, 32'h80, 16'h1234);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_reset();
    rst_ni = 1'b1;

    // Round robin: all four ports request continuously.
    for (int k = 0; k < 5; k++) begin
      clear_all();
      for (int p = 0; p < N; p++) set_req(p, 1'b1, 1'b0, 1'b0, 32'(p * 16 + k * 2), 16'h0);
      #2;
      check("rr seq gnt", 32'(gnt_s[0]), 32'd1 << (k % 4));
      step();
    end

    // Fixed priority: ports 1 and 3 read.
    clear_all();
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h10, 16'h0);
    set_req(3, 1'b1, 1'b0, 1'b0, 32'h20, 16'h0);
    #2;
    check("fix gnt p1", 32'(gnt_s[1]), 32'h2);
    check("fix addr p1", 32'(mem_addr_s[1]), 32'h008);
    step();
    clear_all();
    #2;
    check("fix rsp p1", 32'(rsp_valid_s[1]), 32'h2);
    step();

    // Lock: port 2 bursts writes while port 0 keeps requesting.
    clear_all();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h300, 16'h0);
    set_req(2, 1'b1, 1'b1, 1'b1, 32'h100, 16'h1111);
    #2; check("lock beat1 gnt", 32'(gnt_s[0]), 32'h4); step();
    set_req(2, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    #2; check("lock idle gnt", 32'(gnt_s[0]), 32'h0); step();
    set_req(2, 1'b1, 1'b1, 1'b1, 32'h104, 16'h2222);
    #2; check("lock beat2 gnt", 32'(gnt_s[0]), 32'h4); step();
    set_req(2, 1'b1, 1'b1, 1'b0, 32'h108, 16'h3333);
    #2; check("lock beat3 gnt", 32'(gnt_s[0]), 32'h4); step();
    clear_all();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h300, 16'h0);
    set_req(3, 1'b1, 1'b0, 1'b0, 32'h200, 16'h0);
    #2; check("after lock gnt", 32'(gnt_s[0]), 32'h8); step();
    clear_all();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h300, 16'h0);
    #2; check("p0 finally gnt", 32'(gnt_s[0]), 32'h1); step();

    // Byte swap on write and read.
    clear_all();
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h4, 16'h12AB);
    #2;
    check("swap wdata", 32'(mem_wdata_s[0]), 32'hAB12);
    check("swap addr", 32'(mem_addr_s[0]), 32'h002);
    step();
    clear_all();
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h4, 16'h0);
    step();
    clear_all();
    mem_rdata_i = 16'h3456;
    #2;
    check("swap rdata", 32'(rsp_rdata_s[0]), 32'h5634);
    step();

    // Idle.
    clear_all();
    #2;
    for (int m = 0; m < 2; m++) begin
      check(nm(m, "idle gnt"), 32'(gnt_s[m]), 32'd0);
      check(nm(m, "idle addr"), 32'(mem_addr_s[m]), 32'd0);
      check(nm(m, "idle re/we"), 32'({mem_re_s[m], mem_we_s[m]}), 32'd0);
      check(nm(m, "idle rsp"), 32'(rsp_valid_s[m]), 32'd0);
    end
    step();

    // Reset right after a port-1 read grant.
    clear_all();
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h30, 16'h0);
    step();
    rst_ni = 1'b0;
    model_reset();
    clear_all();
    #2;
    check_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int p = 0; p < N; p++) set_req(p, 1'b1, 1'b0, 1'b0, 32'(p * 4), 16'h0);
    #2;
    check("post-rst rr gnt", 32'(gnt_s[0]), 32'h1);
    step();

    // Randomised traffic against the model.
    repeat (400) begin
      for (int p = 0; p < N; p++) begin
        set_req(p, ($urandom % 4) != 0, 1'($urandom), ($urandom % 4) == 0,
                $urandom, 16'($urandom));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_n.md
# mem_arbiter_n

Parametrised N-port arbiter in front of the single-port synchronous data memory. It generalises the two-port instruction/data arbiter to `NUM_PORTS` requesters with configurable data and address width. It offers fixed-priority or round-robin selection, a lock mechanism for back-to-back bursts, and per-port routing of read responses. It sits between the pipeline/DMA masters and the memory macro, which has a 1-cycle read latency.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `ADDR_W`, 32: requester byte-address width.
- `DATA_W`, 16: data width; a multiple of 8.
- `MEM_AW`, 12: memory word-address width.
- `RR_MODE`, 1: 1 selects round-robin; 0 selects fixed priority (port 0 highest).
- `SWAP_BYTES`, 1: 1 reverses the byte order of write data and read data.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in `NUM_PORTS`: per-port request.
- `req_we_i` in `NUM_PORTS`: per-port write (1) / read (0).
- `req_lock_i` in `NUM_PORTS`: keep the grant after this beat.
- `req_addr_i` in `NUM_PORTS`×`ADDR_W`: byte addresses.
- `req_wdata_i` in `NUM_PORTS`×`DATA_W`: write data.
- `gnt_o` out `NUM_PORTS`: one-hot grant, combinational.
- `mem_addr_o` out `MEM_AW`: word address.
- `mem_re_o` out 1: memory read enable.
- `mem_we_o` out 1: memory write enable.
- `mem_wdata_o` out `DATA_W`: memory write data.
- `mem_rdata_i` in `DATA_W`: memory read data, valid 1 cycle after `mem_re_o`.
- `rsp_valid_o` out `NUM_PORTS`: one-hot read-response strobe.
- `rsp_rdata_o` out `DATA_W`: read data, shared by all ports.

## Operation
Handshake:
- A beat transfers when `req_valid_i[p] & gnt_o[p]`.
- A requester holds its address, data and `we` until granted.
- `gnt_o` is at most one-hot, and is zero when no request is valid.

Selection:
- Fixed mode: lowest valid index wins.
- RR mode: first valid index at or after `rr_ptr`, scanning upward with wrap-around.
- `rr_ptr` resets to 0. It updates to (winner+1) mod `NUM_PORTS` on every transferred beat that is not locked.

FSM, states `ARB` and `LOCKED`:
- `ARB`: grant according to the selection rule. On a transfer with `req_lock_i[w]` set, go to `LOCKED` and record `lock_owner = w`.
- `LOCKED`: only `lock_owner` may be granted; all other ports see `gnt_o = 0`.
  - A transfer with `req_lock_i` clear returns to `ARB` and advances `rr_ptr` past the owner.
  - While locked, `req_valid_i[owner]=0` gives idle cycles. The lock is held indefinitely until the owner issues an unlocked beat.
- Reset state: `ARB`.

Memory drive (combinational from the granted port):
- `mem_addr_o = req_addr >> log2(DATA_W/8)`, truncated to `MEM_AW` bits.
- `mem_re_o = ~we`, `mem_we_o = we`.
- `mem_wdata_o` is byte-reversed when `SWAP_BYTES=1`, otherwise passed through. It is 0 when not writing.
- With no grant, all memory outputs are 0.

Response path:
- A read transfer from port p in cycle n gives `rsp_valid_o[p]=1` in cycle n+1.
- `rsp_rdata_o` is `mem_rdata_i`, byte-swapped per `SWAP_BYTES`; it is combinational from the registered port tag.
- Writes produce no response.

Reset:
- While `rst_ni=0`: `gnt_o`, `mem_*_o`, `rsp_valid_o` and `rsp_rdata_o` are all 0, and the FSM and `rr_ptr` are cleared.
- A read granted in the cycle before reset assertion produces no response.

## Timing
- Grant: combinational, same cycle as the request; zero-cycle arbitration.
- Throughput: one beat per cycle; back-to-back reads are fully pipelined.
- Read latency: exactly 1 cycle from the transfer to `rsp_valid_o`.
- State registers: FSM state, `lock_owner`, `rr_ptr`, response tag (`valid` + port index).
- Simultaneous events:
  - A lock request and a higher-priority request in the same `ARB` cycle: priority decides first, then the lock applies to the winner only.
  - A new read transfer coinciding with a pending response is legal; the two are independent.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_e` (`ARB`, `LOCKED`).
  - A function `byte_swap(DATA_W)`.
  - Constant `PORT_IDX_W = $clog2(NUM_PORTS)` helper.
- Sub-module `rr_picker`: a parametrised priority/round-robin one-hot picker with inputs `req`, `ptr`, `rr_en` and output one-hot `sel`. It is reused for the fixed mode with `ptr=0`.

## Test plan
- **Fixed priority:** `RR_MODE=0`, ports 1 and 3 request reads at addresses 0x10/0x20 → `gnt_o=4'b0010`, `mem_addr_o=0x008`. The next cycle gives `rsp_valid_o=4'b0010`.
- **Round robin:** `RR_MODE=1`, all 4 ports request continuously → grant sequence 0,1,2,3,0 on consecutive cycles.
- **Lock:** port 2 issues 3 writes with lock=1,1,0 while port 0 also requests → port 0 is granted only after the third write. `rr_ptr` then equals 3, so port 3 wins next if it is requesting.
- **Byte swap:** write 0x12AB to byte address 0x4 → `mem_wdata_o=0xAB12`, `mem_addr_o=0x002`. A read returning `mem_rdata_i=0x3456` gives `rsp_rdata_o=0x5634`.
- **Reset mid-operation:** assert `rst_ni=0` the cycle after a port-1 read grant → `rsp_valid_o` stays 0. After release, FSM is in `ARB` and `rr_ptr=0`.
- **Idle:** no requests → all `gnt_o`, `mem_re_o`, `mem_we_o` and `rsp_valid_o` are 0, and `mem_addr_o=0`.
